// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multiply/divide sequencer; the control unit imports
// the same op codes and HI/LO source selects.
package muldiv_sequencer_pkg;

   typedef enum logic [1:0] {
      OP_MULT = 2'b00,
      OP_DIV  = 2'b01,
      OP_DIVM = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_RUN,
      ST_WRITE,
      ST_EXC
   } state_e;

   localparam logic HILO_SRC_MULT = 1'b0;
   localparam logic HILO_SRC_DIV  = 1'b1;

   localparam logic DIV_SRC_REGS  = 1'b0;
   localparam logic DIV_SRC_MEM   = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/muldiv_timeout_counter.sv
// Clearable, saturating up-counter with a terminal-count compare; shared by the
// operand-fetch wait and the run-phase timeout.
module muldiv_timeout_counter #(
   parameter int W = 7
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] terminal,
   output logic [W-1:0] count,
   output logic         at_terminal
);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk) begin
      if (reset || clear)
         count <= '0;
      else if (enable && (count != '1))
         count <= count + W'(1);
   end

   assign at_terminal = (count >= terminal);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV/DIVM request through the shared mul/div unit and
// commits the result to HI/LO, or raises a one-cycle exception pulse.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64,
   parameter int MEM_WAIT       = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic [1:0] req_op,
   output logic       req_ready,
   input  logic       abort,
   input  logic       div_finished,
   input  logic       div_0,
   input  logic       mult_calculando,
   output logic       div_start,
   output logic       mult_start,
   output logic       div_control,
   output logic       HiLo_control,
   output logic       HiLo_w,
   output logic       busy,
   output logic       done,
   output logic       div_zero_exc,
   output logic       err_timeout
);

   localparam int CNT_W = $clog2(max_int(TIMEOUT_CYCLES, MEM_WAIT) + 1);
   localparam logic [CNT_W-1:0] FETCH_LAST = CNT_W'(MEM_WAIT - 1);
   localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

   state_e           state;
   op_e              op_q;
   op_e              req_kind;
   logic [CNT_W-1:0] cnt;
   logic             cnt_at_term;
   logic             cnt_clear;
   logic             cnt_enable;
   logic [CNT_W-1:0] cnt_terminal;
   logic             mult_done;
   logic             unit_done;

   assign req_kind     = op_e'(req_op);
   assign cnt_clear    = (state == ST_IDLE) || (state == ST_ISSUE);
   assign cnt_enable   = (state == ST_FETCH) || (state == ST_RUN);
   assign cnt_terminal = (state == ST_FETCH) ? FETCH_LAST : RUN_LAST;

   // The multiplier's busy flag lags its start pulse, so the first RUN cycle is ignored.
   assign mult_done = (cnt != '0) && !mult_calculando;
   assign unit_done = (op_q == OP_MULT) ? mult_done : div_finished;

   muldiv_timeout_counter #(.W(CNT_W)) u_counter (
      .clk         (clk),
      .reset       (reset),
      .clear       (cnt_clear),
      .enable      (cnt_enable),
      .terminal    (cnt_terminal),
      .count       (cnt),
      .at_terminal (cnt_at_term)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         op_q         <= OP_MULT;
         req_ready    <= 1'b1;
         busy         <= 1'b0;
         div_control  <= DIV_SRC_REGS;
         HiLo_control <= HILO_SRC_MULT;
         div_start    <= 1'b0;
         mult_start   <= 1'b0;
         HiLo_w       <= 1'b0;
         done         <= 1'b0;
         div_zero_exc <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         div_start    <= 1'b0;
         mult_start   <= 1'b0;
         HiLo_w       <= 1'b0;
         done         <= 1'b0;
         div_zero_exc <= 1'b0;
         err_timeout  <= 1'b0;

         if (abort && (state != ST_IDLE)) begin
            state        <= ST_IDLE;
            req_ready    <= 1'b1;
            busy         <= 1'b0;
            div_control  <= DIV_SRC_REGS;
            HiLo_control <= HILO_SRC_MULT;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  if (req_valid && (req_kind != OP_RSVD)) begin
                     op_q         <= req_kind;
                     req_ready    <= 1'b0;
                     busy         <= 1'b1;
                     div_control  <= (req_kind == OP_DIVM) ? DIV_SRC_MEM : DIV_SRC_REGS;
                     HiLo_control <= (req_kind == OP_MULT) ? HILO_SRC_MULT : HILO_SRC_DIV;
                     if (req_kind == OP_DIVM) begin
                        state <= ST_FETCH;
                     end else begin
                        state      <= ST_ISSUE;
                        mult_start <= (req_kind == OP_MULT);
                        div_start  <= (req_kind == OP_DIV);
                     end
                  end
               end
               ST_FETCH: begin
                  if (cnt_at_term) begin
                     state     <= ST_ISSUE;
                     div_start <= 1'b1;
                  end
               end
               ST_ISSUE: state <= ST_RUN;
               ST_RUN: begin
                  if ((op_q != OP_MULT) && div_0) begin
                     state        <= ST_EXC;
                     div_zero_exc <= 1'b1;
                  end else if (unit_done) begin
                     state  <= ST_WRITE;
                     HiLo_w <= 1'b1;
                     done   <= 1'b1;
                  end else if (cnt_at_term) begin
                     state       <= ST_EXC;
                     err_timeout <= 1'b1;
                  end
               end
               ST_WRITE, ST_EXC: begin
                  state        <= ST_IDLE;
                  req_ready    <= 1'b1;
                  busy         <= 1'b0;
                  div_control  <= DIV_SRC_REGS;
                  HiLo_control <= HILO_SRC_MULT;
               end
               default: begin
                  state     <= ST_IDLE;
                  req_ready <= 1'b1;
                  busy      <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
